// File: rtl/capture_buf_ctrl.sv
// capture_buf_ctrl
// Pre/post-trigger ring-buffer sequencer for an external simple-dual-port
// sample BRAM with a one-cycle registered read. The block captures
// samples circularly until a trigger arrives. It then writes a programmed
// number of post-trigger samples. Finally it streams the captured window,
// oldest sample first, over a valid/ready port.

module capture_buf_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic                  smp_valid,
    input  logic [DATA_WIDTH-1:0] smp_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  full
);

    // Fill saturates at DEPTH, so the counter carries one extra bit.
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   ONE_F   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_POST     = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_VALID = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r;
    logic [ADDR_WIDTH-1:0]   post_cnt_r;
    logic [ADDR_WIDTH:0]     fill_r;
    logic [ADDR_WIDTH:0]     rd_cnt_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_last_r;

    logic                    wr_en_s;
    logic                    enter_rd_s;
    logic                    hs_s;
    logic [ADDR_WIDTH-1:0]   wr_ptr_nx_s;
    logic [ADDR_WIDTH:0]     fill_nx_s;
    logic                    full_nx_s;

    // Pointer and fill values as they will be after this cycle's write.
    // Readout entry uses them so that a write in the trigger/final cycle
    // is part of the captured window.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r;
        fill_nx_s   = fill_r;
        if (wr_en_s) begin
            wr_ptr_nx_s = wr_ptr_r + ONE_A;
            if (fill_r == DEPTH_C) begin
                fill_nx_s = fill_r;
            end else begin
                fill_nx_s = fill_r + ONE_F;
            end
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
            fill_nx_s   = fill_r;
        end
        full_nx_s = (fill_nx_s == DEPTH_C);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort overrides every other request.
    always_comb begin
        next_state_s = state_r;
        enter_rd_s   = 1'b0;
        if (abort) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arm) begin
                        next_state_s = S_ARMED;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (trig) begin
                        if (post_len == '0) begin
                            enter_rd_s   = 1'b1;
                            next_state_s = (fill_nx_s == '0) ? S_IDLE : S_RD_ISSUE;
                        end else begin
                            next_state_s = S_POST;
                        end
                    end else begin
                        next_state_s = S_ARMED;
                    end
                end
                S_POST: begin
                    if (wr_en_s && (post_cnt_r == ONE_A)) begin
                        enter_rd_s   = 1'b1;
                        next_state_s = (fill_nx_s == '0) ? S_IDLE : S_RD_ISSUE;
                    end else begin
                        next_state_s = S_POST;
                    end
                end
                S_RD_ISSUE: begin
                    next_state_s = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    next_state_s = S_RD_VALID;
                end
                S_RD_VALID: begin
                    if (out_ready) begin
                        next_state_s = (rd_cnt_r > ONE_F) ? S_RD_ISSUE : S_IDLE;
                    end else begin
                        next_state_s = S_RD_VALID;
                    end
                end
                default: begin
                    next_state_s = S_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs: the write port is live only while capturing.
    always_comb begin
        wr_en_s = 1'b0;
        hs_s    = 1'b0;
        case (state_r)
            S_ARMED, S_POST: begin
                wr_en_s = smp_valid;
            end
            S_RD_VALID: begin
                hs_s = out_ready & ~abort;
            end
            default: begin
                wr_en_s = 1'b0;
                hs_s    = 1'b0;
            end
        endcase
    end

    assign ram_wr_en   = wr_en_s;
    assign ram_wr_addr = wr_ptr_r;
    assign ram_wr_data = wr_en_s ? smp_data : '0;
    // rd_ptr is itself a register and is stable for the whole RD_ISSUE cycle.
    assign ram_rd_addr = rd_ptr_r;
    assign busy        = (state_r != S_IDLE);
    assign full        = (fill_r == DEPTH_C);
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;

    // Capture pointers, post-trigger counter and readout pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            fill_r     <= '0;
            post_cnt_r <= '0;
            rd_ptr_r   <= '0;
            rd_cnt_r   <= '0;
        end else begin
            if ((state_r == S_IDLE) && arm && !abort) begin
                wr_ptr_r <= '0;
                fill_r   <= '0;
            end else if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_nx_s;
                fill_r   <= fill_nx_s;
            end

            if ((state_r == S_ARMED) && trig && !abort) begin
                post_cnt_r <= post_len;
            end else if ((state_r == S_POST) && wr_en_s) begin
                post_cnt_r <= post_cnt_r - ONE_A;
            end

            // Once the ring has wrapped, the oldest sample sits at the next
            // write location.
            if (enter_rd_s) begin
                rd_ptr_r <= full_nx_s ? wr_ptr_nx_s : '0;
                rd_cnt_r <= fill_nx_s;
            end else if (hs_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_A;
                rd_cnt_r <= rd_cnt_r - ONE_F;
            end
        end
    end

    // Readout register: holds BRAM data and the last flag for the whole
    // valid phase, so they stay stable while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= (next_state_s == S_RD_VALID);
            if ((state_r == S_RD_WAIT) && !abort) begin
                out_data_r <= ram_rd_data;
                out_last_r <= (rd_cnt_r == ONE_F);
            end
        end
    end

endmodule

// File: doc/capture_buf_ctrl.md
# capture_buf_ctrl

Single-clock capture controller that sequences a simple-dual-port sample BRAM as a pre/post-trigger ring buffer for baseband samples in the RFID reader receive path. It runs in four phases: arm, fill circularly, trigger, write a programmed number of post-trigger samples. It then streams the captured window, oldest sample first, over a valid/ready port, absorbing the BRAM's one-cycle registered read latency. The BRAM (2**ADDR_WIDTH x DATA_WIDTH, registered read) is instantiated beside this block, with both of its clock ports tied to `clk`.

## Interface
- ADDR_WIDTH, 8, BRAM address width; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 12, sample width
- clk  in  1  single clock for controller and BRAM
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  start capture (IDLE only)
- abort  in  1  return to IDLE from any state
- trig  in  1  trigger (ARMED only)
- post_len  in  ADDR_WIDTH  post-trigger sample count, sampled when trig is accepted
- smp_valid  in  1  input sample strobe
- smp_data  in  DATA_WIDTH  input sample
- ram_wr_en  out  1  BRAM write enable
- ram_wr_addr  out  ADDR_WIDTH  BRAM write address
- ram_wr_data  out  DATA_WIDTH  BRAM write data
- ram_rd_addr  out  ADDR_WIDTH  BRAM read address (registered)
- ram_rd_data  in  DATA_WIDTH  BRAM read data, valid one cycle after ram_rd_addr
- out_valid  out  1  readout sample valid
- out_ready  in  1  readout sink ready
- out_data  out  DATA_WIDTH  readout sample
- out_last  out  1  marks final readout sample
- busy  out  1  high in any state except IDLE
- full  out  1  fill count has saturated at DEPTH

## Operation
- States: IDLE, ARMED, POST, RD_ISSUE, RD_WAIT, RD_VALID.
- IDLE: on arm, go to ARMED; clear wr_ptr and fill to 0.
- ARMED, POST: each smp_valid writes in the same cycle: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=smp_data. On the next edge wr_ptr increments mod DEPTH.
- fill: ADDR_WIDTH+1 bits; +1 per write, saturating at DEPTH; full = (fill==DEPTH).
- ARMED + trig:
  - The sample written that cycle (if any) counts as pre-trigger.
  - post_len is latched into post_cnt.
  - post_len=0 → go to RD_ISSUE; otherwise → POST.
- POST: each write decrements post_cnt; the write that takes it to 0 moves the FSM to RD_ISSUE. trig is ignored in POST.
- Entering readout:
  - rd_ptr = full ? wr_ptr : 0
  - rd_cnt = fill
  - If fill==0 (trig before any sample), go straight to IDLE with no output.
- RD_ISSUE: ram_rd_addr=rd_ptr → RD_WAIT.
- RD_WAIT: latch ram_rd_data into out_data; out_last = (rd_cnt==1) → RD_VALID.
- RD_VALID: out_valid=1 until out_ready.
  - On handshake: rd_ptr+1 mod DEPTH, rd_cnt-1.
  - Then RD_ISSUE if rd_cnt was >1, else IDLE.
- Ignored inputs:
  - smp_valid outside ARMED/POST
  - arm outside IDLE
  - trig outside ARMED
- abort: next state IDLE from any state; out_valid and ram_wr_en drop next cycle; pointers cleared at the next arm. abort beats arm and trig in the same cycle.
- ram_wr_en=0 in every state except ARMED/POST.

## Timing
- Reset values: state IDLE; wr_ptr, rd_ptr, fill, post_cnt, rd_cnt = 0; ram_wr_en=0; ram_wr_addr=0; ram_wr_data=0; ram_rd_addr=0; out_valid=0; out_data=0; out_last=0; busy=0; full=0.
- Write path: combinational from smp_valid/smp_data; zero-latency write in the sample's cycle.
- Trigger-to-readout, post_len=0: RD_ISSUE on the cycle after trig; first out_valid 2 cycles later.
- Readout throughput: one sample per 3 cycles with out_ready held high (RD_ISSUE, RD_WAIT, RD_VALID).
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- Wrap-around: wr_ptr DEPTH-1→0 and rd_ptr DEPTH-1→0 are seamless. Once full, the oldest samples are overwritten.
- Async reset mid-readout: out_valid falls immediately; there is no partial handshake.

## Test plan
- Reset mid-POST (ADDR_WIDTH=4) -> all outputs at reset values immediately; arm afterwards starts with fill=0.
- Arm; samples 0..5 with trig on sample 5; post_len=3; samples 6..8 -> read 0..8, out_last only on 8, then IDLE, busy=0.
- Arm; samples 0..19 with trig on sample 19; post_len=4; samples 20..23 -> full=1; read 16 samples 8..23 in order.
- post_len=0, trig on sample 3 -> RD_ISSUE the next cycle; read 0..3; no further writes accepted.
- Readout with out_ready held low 5 cycles on each of the first 2 samples -> out_data/out_last stable; no loss or duplication; 3-cycle/sample cadence once ready is high.
- abort in POST with arm held high the same cycle -> IDLE next cycle, ram_wr_en=0; a new arm then captures from address 0.
